cla_addsub_pipe: RTL

- Parametrised, pipelined carry-lookahead adder/subtractor; the multi-bit successor of the team's 4-bit CLA add/sub.
- Splits a WIDTH-bit operation into GROUP-bit CLA slices, one slice per pipeline stage, with the inter-group carry registered between stages.
- Adds per-beat mode select, valid/ready handshake with backpressure, and signed-overflow and zero flags.
- Sits between operand-fetch logic and a result sink in the datapath.

---
 rtl/cla_addsub_pipe_if.sv | 27 ++
 rtl/cla_addsub_pipe.sv | 128 ++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe_if.sv
// rtl/cla_addsub_pipe_if.sv - operand/result handshake bundle for cla_addsub_pipe
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, control, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, cin, control, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - pipelined carry-lookahead adder/subtractor, one GROUP-bit slice per stage
module cla_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input logic              clk,
  input logic              rst,
  cla_addsub_pipe_if.slave bus
);
  localparam int NG = WIDTH / GROUP;

  if (GROUP < 1 || GROUP > 8 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_param_check
    $error("cla_addsub_pipe: WIDTH must be a nonzero multiple of GROUP and GROUP must be 1..8");
  end

  // Every carry is a flat sum of products of P/G and the slice carry-in; no ripple.
  function automatic logic [GROUP:0] cla_slice(input logic [GROUP-1:0] p,
                                               input logic [GROUP-1:0] g,
                                               input logic             ci);
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      term = ci;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic [WIDTH-1:0] bx_in;
  logic             c0;
  logic             en;

  assign bx_in        = bus.b ^ {WIDTH{bus.control}};
  assign c0           = bus.cin ^ bus.control;
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < NG; k++) begin : g_stage
    localparam int LO  = k * GROUP;
    localparam int REM = WIDTH - LO - GROUP;

    // a_rest/b_rest: operand bits from this slice upward; s_all: sum bits from bit 0 to this slice.
    logic [WIDTH-LO-1:0] a_rest;
    logic [WIDTH-LO-1:0] b_rest;
    logic [LO+GROUP-1:0] s_all;
    logic [LO+GROUP-1:0] s_q;
    logic [GROUP-1:0]    p;
    logic [GROUP-1:0]    g;
    logic [GROUP:0]      c;
    logic                v_in;
    logic                ci;
    logic                v_q;
    logic                c_q;

    if (k == 0) begin : g_src
      assign a_rest = bus.a;
      assign b_rest = bx_in;
      assign ci     = c0;
      assign v_in   = bus.in_valid;
      assign s_all  = p ^ c[GROUP-1:0];
    end else begin : g_src
      assign a_rest = g_stage[k-1].g_fwd.a_q;
      assign b_rest = g_stage[k-1].g_fwd.b_q;
      assign ci     = g_stage[k-1].c_q;
      assign v_in   = g_stage[k-1].v_q;
      assign s_all  = {p ^ c[GROUP-1:0], g_stage[k-1].s_q};
    end

    assign p = a_rest[GROUP-1:0] ^ b_rest[GROUP-1:0];
    assign g = a_rest[GROUP-1:0] & b_rest[GROUP-1:0];
    assign c = cla_slice(p, g, ci);

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        c_q <= c[GROUP];
        s_q <= s_all;
      end
    end

    // Operand bits of later slices ride along until their stage.
    if (REM > 0) begin : g_fwd
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_rest[WIDTH-LO-1:GROUP];
          b_q <= b_rest[WIDTH-LO-1:GROUP];
        end
      end
    end

    if (k == NG - 1) begin : g_last
      logic cm_q;
      logic z_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          cm_q <= 1'b0;
          z_q  <= 1'b0;
        end else if (en) begin
          cm_q <= c[GROUP-1];
          z_q  <= (s_all == '0);
        end
      end
    end
  end

  assign bus.out_valid = g_stage[NG-1].v_q;
  assign bus.sum       = g_stage[NG-1].s_q;
  assign bus.cout      = g_stage[NG-1].c_q;
  assign bus.overflow  = g_stage[NG-1].c_q ^ g_stage[NG-1].g_last.cm_q;
  assign bus.zero      = g_stage[NG-1].g_last.z_q;
endmodule
